// File: rtl/lsu_dual_buffered.sv
// Dual-lane load/store unit with an in-order store buffer in front of a local data cache.
// Loads forward from the buffer (youngest match first) and, on lane B, from a same-cycle lane A store.
module lsu_dual_buffered #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int SB_DEPTH = 4,
  parameter int OPC_W    = 7,
  parameter int RA_W     = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enableA_i,
  input  logic              enableB_i,
  input  logic              isWbA_i,
  input  logic              isWbB_i,
  input  logic [OPC_W-1:0]  opCodeA_i,
  input  logic [OPC_W-1:0]  opCodeB_i,
  input  logic [RA_W-1:0]   wbAddressA_i,
  input  logic [RA_W-1:0]   wbAddressB_i,
  input  logic [DATA_W-1:0] pOperandA_i,
  input  logic [DATA_W-1:0] pOperandB_i,
  input  logic [DATA_W-1:0] sOperandA_i,
  input  logic [DATA_W-1:0] sOperandB_i,
  output logic              ready_o,
  output logic              wbEnableA_o,
  output logic              wbEnableB_o,
  output logic [RA_W-1:0]   wbAddressA_o,
  output logic [RA_W-1:0]   wbAddressB_o,
  output logic [DATA_W-1:0] wbDataA_o,
  output logic [DATA_W-1:0] wbDataB_o,
  output logic              faultA_o,
  output logic              faultB_o,
  output logic              sbEmpty_o
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_LDM = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(12);

  logic [PW-1:0]     head, tail, tail_b;
  logic [CW-1:0]     count, count_next;
  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [DATA_W-1:0] cache [DEPTH];

  logic              acc_a, acc_b, in_a, in_b;
  logic              ldi_a, ldi_b, ldm_a, ldm_b, st_a, st_b;
  logic              flt_a, flt_b, deq;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] fwd_a, fwd_b, ld_a, ld_b;

  // Two free slots guarantee room for a dual store regardless of drain.
  assign ready_o = (count <= CW'(SB_DEPTH - 2));

  assign acc_a  = enableA_i & ready_o;
  assign acc_b  = enableB_i & ready_o;
  assign addr_a = sOperandA_i[ADDR_W-1:0];
  assign addr_b = sOperandB_i[ADDR_W-1:0];
  assign in_a   = sOperandA_i < DATA_W'(DEPTH);
  assign in_b   = sOperandB_i < DATA_W'(DEPTH);

  assign ldi_a = acc_a & (opCodeA_i == OP_LDI);
  assign ldi_b = acc_b & (opCodeB_i == OP_LDI);
  assign ldm_a = acc_a & (opCodeA_i == OP_LDM) & in_a;
  assign ldm_b = acc_b & (opCodeB_i == OP_LDM) & in_b;
  assign st_a  = acc_a & (opCodeA_i == OP_ST) & in_a;
  assign st_b  = acc_b & (opCodeB_i == OP_ST) & in_b;
  assign flt_a = acc_a & ((opCodeA_i == OP_LDM) | (opCodeA_i == OP_ST)) & ~in_a;
  assign flt_b = acc_b & ((opCodeB_i == OP_LDM) | (opCodeB_i == OP_ST)) & ~in_b;

  assign deq        = (count != '0);
  assign tail_b     = tail + PW'(st_a);
  assign count_next = count + CW'(st_a) + CW'(st_b) - CW'(deq);

  // Walk oldest to youngest so the last match (youngest) wins; the draining head is included.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (sb_addr[head + PW'(i)] == addr_a) begin
          hit_a = 1'b1;
          fwd_a = sb_data[head + PW'(i)];
        end
        if (sb_addr[head + PW'(i)] == addr_b) begin
          hit_b = 1'b1;
          fwd_b = sb_data[head + PW'(i)];
        end
      end
    end
  end

  assign ld_a = hit_a ? fwd_a : cache[addr_a];
  assign ld_b = (st_a && (addr_a == addr_b)) ? pOperandA_i :
                hit_b ? fwd_b : cache[addr_b];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      sbEmpty_o    <= 1'b1;
      wbEnableA_o  <= 1'b0;
      wbEnableB_o  <= 1'b0;
      wbAddressA_o <= '0;
      wbAddressB_o <= '0;
      wbDataA_o    <= '0;
      wbDataB_o    <= '0;
      faultA_o     <= 1'b0;
      faultB_o     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) cache[i] <= '0;
    end else begin
      wbEnableA_o <= (ldi_a | ldm_a) & isWbA_i;
      wbEnableB_o <= (ldi_b | ldm_b) & isWbB_i;
      faultA_o    <= flt_a;
      faultB_o    <= flt_b;
      if (ldi_a | ldm_a) begin
        wbAddressA_o <= wbAddressA_i;
        wbDataA_o    <= ldi_a ? sOperandA_i : ld_a;
      end
      if (ldi_b | ldm_b) begin
        wbAddressB_o <= wbAddressB_i;
        wbDataB_o    <= ldi_b ? sOperandB_i : ld_b;
      end
      if (deq) begin
        cache[sb_addr[head]] <= sb_data[head];
        head                 <= head + 1'b1;
      end
      // Lane A is older, so it takes the tail slot first.
      if (st_a) begin
        sb_addr[tail] <= addr_a;
        sb_data[tail] <= pOperandA_i;
      end
      if (st_b) begin
        sb_addr[tail_b] <= addr_b;
        sb_data[tail_b] <= pOperandB_i;
      end
      tail      <= tail_b + PW'(st_b);
      count     <= count_next;
      sbEmpty_o <= (count_next == '0);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) assert (count <= CW'(SB_DEPTH));
  end

endmodule

// File: tb/tb_lsu_dual_buffered.sv
// Scoreboard bench for lsu_dual_buffered: a flat-memory reference model predicts each cycle's outputs,
// a separate monitor compares them one cycle later.
module tb_lsu_dual_buffered;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEP = 20;
  localparam int SBD = 4;
  localparam int OW = 7;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          enableA_i = 0, enableB_i = 0, isWbA_i = 0, isWbB_i = 0;
  logic [OW-1:0] opCodeA_i = '0, opCodeB_i = '0;
  logic [RW-1:0] wbAddressA_i = '0, wbAddressB_i = '0;
  logic [DW-1:0] pOperandA_i = '0, pOperandB_i = '0, sOperandA_i = '0, sOperandB_i = '0;
  logic          ready_o, wbEnableA_o, wbEnableB_o, faultA_o, faultB_o, sbEmpty_o;
  logic [RW-1:0] wbAddressA_o, wbAddressB_o;
  logic [DW-1:0] wbDataA_o, wbDataB_o;

  always #5 clk = ~clk;

  lsu_dual_buffered #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .SB_DEPTH(SBD), .OPC_W(OW), .RA_W(RW)) dut (
    .clock_i(clk), .reset_i(reset_i),
    .enableA_i(enableA_i), .enableB_i(enableB_i), .isWbA_i(isWbA_i), .isWbB_i(isWbB_i),
    .opCodeA_i(opCodeA_i), .opCodeB_i(opCodeB_i),
    .wbAddressA_i(wbAddressA_i), .wbAddressB_i(wbAddressB_i),
    .pOperandA_i(pOperandA_i), .pOperandB_i(pOperandB_i),
    .sOperandA_i(sOperandA_i), .sOperandB_i(sOperandB_i),
    .ready_o(ready_o),
    .wbEnableA_o(wbEnableA_o), .wbEnableB_o(wbEnableB_o),
    .wbAddressA_o(wbAddressA_o), .wbAddressB_o(wbAddressB_o),
    .wbDataA_o(wbDataA_o), .wbDataB_o(wbDataB_o),
    .faultA_o(faultA_o), .faultB_o(faultB_o), .sbEmpty_o(sbEmpty_o)
  );

  typedef struct {
    bit            en;
    bit            wb;
    logic [OW-1:0] op;
    logic [RW-1:0] ra;
    logic [DW-1:0] p;
    logic [DW-1:0] s;
  } lane_t;

  typedef struct {
    bit            rst;
    bit            wa, fa, wb, fb, empty;
    logic [DW-1:0] da, db;
    logic [RW-1:0] ra, rb;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem [DEP];
  int            cnt_m = 0;
  int            checks = 0;
  int            errors = 0;
  bit            saw_stall = 0;

  function automatic lane_t L(bit en, bit wb, int op, int ra, logic [DW-1:0] p, logic [DW-1:0] s);
    lane_t l;
    l.en = en; l.wb = wb; l.op = OW'(op); l.ra = RW'(ra); l.p = p; l.s = s;
    return l;
  endfunction

  function automatic lane_t rand_lane();
    lane_t l;
    int    k;
    l.en = ($urandom_range(0, 3) != 0);
    l.wb = $urandom_range(0, 1) != 0;
    k = $urandom_range(0, 9);
    l.op = (k == 0) ? OW'(0) : (k == 1) ? OW'(5) : (k <= 3) ? OW'(10) : (k <= 6) ? OW'(11) : OW'(12);
    l.ra = RW'($urandom);
    l.p  = DW'($urandom);
    k = $urandom_range(0, 15);
    if (l.op == OW'(10)) l.s = DW'($urandom);
    else if (k == 0)     l.s = DW'($urandom_range(DEP, 40));
    else if (k == 1)     l.s = DW'($urandom_range(DEP, 65535));
    else if (k < 9)      l.s = DW'($urandom_range(0, 5));
    else                 l.s = DW'($urandom_range(0, DEP - 1));
    return l;
  endfunction

  // Architectural view: every accepted store is immediately visible to later loads in program order.
  function automatic void lane_model(input bit acc, input lane_t l, output bit we, output logic [DW-1:0] d,
                                     output logic [RW-1:0] ra, output bit f, output int enq);
    we = 0; d = '0; ra = l.ra; f = 0; enq = 0;
    if (!acc) return;
    if (l.op == OW'(10)) begin
      we = l.wb; d = l.s;
    end else if (l.op == OW'(11)) begin
      if (l.s >= DW'(DEP)) f = 1;
      else begin we = l.wb; d = mem[int'(l.s)]; end
    end else if (l.op == OW'(12)) begin
      if (l.s >= DW'(DEP)) f = 1;
      else begin mem[int'(l.s)] = l.p; enq = 1; end
    end
  endfunction

  task automatic issue(input bit rst, input lane_t a, input lane_t b);
    exp_t e;
    bit   rdy;
    int   ea, eb;
    @(negedge clk);
    reset_i = rst;
    enableA_i = a.en; isWbA_i = a.wb; opCodeA_i = a.op; wbAddressA_i = a.ra; pOperandA_i = a.p; sOperandA_i = a.s;
    enableB_i = b.en; isWbB_i = b.wb; opCodeB_i = b.op; wbAddressB_i = b.ra; pOperandB_i = b.p; sOperandB_i = b.s;
    rdy = (SBD - cnt_m) >= 2;
    e = '{default: '0};
    if (rst) begin
      e.rst = 1; e.empty = 1;
      for (int i = 0; i < DEP; i++) mem[i] = '0;
      cnt_m = 0;
    end else begin
      checks++;
      if (ready_o !== rdy) begin
        errors++;
        $display("FAIL ready t=%0t got=%b exp=%b", $time, ready_o, rdy);
      end
      if (ready_o === 1'b0) saw_stall = 1;
      lane_model(a.en && rdy, a, e.wa, e.da, e.ra, e.fa, ea);
      lane_model(b.en && rdy, b, e.wb, e.db, e.rb, e.fb, eb);
      cnt_m = cnt_m + ea + eb - ((cnt_m > 0) ? 1 : 0);
      e.empty = (cnt_m == 0);
    end
    q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) issue(0, L(0, 0, 0, 0, 0, 0), L(0, 0, 0, 0, 0, 0));
  endtask

  task automatic drain();
    int guard = 0;
    while (cnt_m != 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    idle(1);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (wbEnableA_o !== e.wa || faultA_o !== e.fa ||
            ((e.wa || e.rst) && (wbDataA_o !== e.da || wbAddressA_o !== (e.rst ? '0 : e.ra)))) begin
          errors++;
          $display("FAIL laneA t=%0t got en=%b d=%h a=%h f=%b exp en=%b d=%h a=%h f=%b", $time,
                   wbEnableA_o, wbDataA_o, wbAddressA_o, faultA_o, e.wa, e.da, e.rst ? '0 : e.ra, e.fa);
        end
        checks++;
        if (wbEnableB_o !== e.wb || faultB_o !== e.fb ||
            ((e.wb || e.rst) && (wbDataB_o !== e.db || wbAddressB_o !== (e.rst ? '0 : e.rb)))) begin
          errors++;
          $display("FAIL laneB t=%0t got en=%b d=%h a=%h f=%b exp en=%b d=%h a=%h f=%b", $time,
                   wbEnableB_o, wbDataB_o, wbAddressB_o, faultB_o, e.wb, e.db, e.rst ? '0 : e.rb, e.fb);
        end
        checks++;
        if (sbEmpty_o !== e.empty) begin
          errors++;
          $display("FAIL sbEmpty t=%0t got=%b exp=%b", $time, sbEmpty_o, e.empty);
        end
      end
    end
  end

  initial begin
    lane_t nop;
    nop = L(0, 0, 0, 0, 0, 0);
    issue(1, nop, nop);
    issue(1, nop, nop);

    // Same-cycle forwarding A store -> B load, then buffer forwarding on the next cycle.
    issue(0, L(1, 0, 12, 0, 16'hBEEF, 7), L(1, 1, 11, 3, 0, 7));
    issue(0, L(1, 1, 11, 4, 0, 7), nop);
    drain();

    // Youngest buffer entry wins.
    issue(0, L(1, 0, 12, 0, 16'h1111, 3), nop);
    issue(0, L(1, 0, 12, 0, 16'h2222, 3), nop);
    issue(0, L(1, 1, 11, 9, 0, 3), nop);
    drain();

    // Out-of-range load on A alongside load-imm on B; full-width compare on the address.
    issue(0, L(1, 1, 11, 1, 0, 25), L(1, 1, 10, 2, 0, 16'h00AA));
    issue(0, L(1, 1, 12, 1, 16'h7777, 16'h0103), L(1, 1, 11, 2, 0, 16'h0104));

    // Independent lanes.
    issue(0, L(1, 1, 0, 6, 16'h1234, 2), L(1, 1, 12, 7, 16'h5A5A, 2));
    drain();
    issue(0, L(1, 1, 11, 8, 0, 2), L(1, 1, 5, 8, 0, 2));

    // Reset mid-drain discards pending stores and clears the cache.
    issue(0, L(1, 0, 12, 0, 16'hAAAA, 4), L(1, 0, 12, 0, 16'hBBBB, 5));
    issue(0, L(1, 0, 12, 0, 16'hCCCC, 6), nop);
    issue(1, rand_lane(), rand_lane());
    issue(0, L(1, 1, 11, 1, 0, 4), L(1, 1, 11, 2, 0, 5));
    issue(0, L(1, 1, 11, 3, 0, 6), nop);

    // Backpressure: dual stores every cycle, then read back every address.
    for (int i = 0; i < 14; i++)
      issue(0, L(1, 0, 12, 0, DW'($urandom), DW'($urandom_range(0, DEP - 1))),
               L(1, 0, 12, 0, DW'($urandom), DW'($urandom_range(0, DEP - 1))));
    checks++;
    if (saw_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall got=%b exp=1", saw_stall);
    end
    drain();
    for (int i = 0; i < DEP; i += 2)
      issue(0, L(1, 1, 11, i, 0, DW'(i)), L(1, 1, 11, i + 1, 0, DW'(i + 1)));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++)
      issue(($urandom_range(0, 99) == 0), rand_lane(), rand_lane());
    drain();
    for (int i = 0; i < DEP; i += 2)
      issue(0, L(1, 1, 11, i, 0, DW'(i)), L(1, 1, 11, i + 1, 0, DW'(i + 1)));
    idle(2);

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dual_buffered.md
Name: lsu_dual_buffered

Overview:
- Parametrised second-generation dual-lane load/store unit for the execute/writeback boundary.
- Lanes A (older) and B (younger) are each issued per cycle. Each lane executes load-immediate, load-from-memory or store-to-memory against a local DEPTH-word data cache.
- Stores pass through an in-order store buffer that drains one entry per cycle. Loads forward from the buffer and from a same-cycle older store.
- Adds backpressure, address-range faults, synchronous reset and fully independent lane decode.

Parameters:
- DATA_W, 16, data and operand width.
- ADDR_W, 5, cache address width; the low ADDR_W bits of the secondary operand form the address.
- DEPTH, 32, cache words; must satisfy DEPTH <= 2^ADDR_W.
- SB_DEPTH, 4, store-buffer entries; power of 2, >= 2.
- OPC_W, 7, opcode width.
- RA_W, 5, register-file writeback address width.

Ports:
- clock_i  in  1  sole clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- enableA_i / enableB_i  in  1  lane valid
- isWbA_i / isWbB_i  in  1  lane requests register writeback
- opCodeA_i / opCodeB_i  in  OPC_W  0 nop, 10 load-imm, 11 load-mem, 12 store-mem
- wbAddressA_i / wbAddressB_i  in  RA_W  destination register
- pOperandA_i / pOperandB_i  in  DATA_W  store data
- sOperandA_i / sOperandB_i  in  DATA_W  immediate (op 10) or memory address (11/12)
- ready_o  out  1  issue accepted this cycle
- wbEnableA_o / wbEnableB_o  out  1  writeback valid
- wbAddressA_o / wbAddressB_o  out  RA_W  writeback register
- wbDataA_o / wbDataB_o  out  DATA_W  writeback data
- faultA_o / faultB_o  out  1  out-of-range access, one-cycle pulse
- sbEmpty_o  out  1  store buffer empty (all stores committed)

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset clears:
  - all registered outputs to 0;
  - store-buffer head, tail and count to 0;
  - all cache words to 0.
- After reset, ready_o=1 and sbEmpty_o=1. Stores pending at reset are discarded. Lane inputs are ignored while reset_i=1.
- ready_o is combinational from the registered count: ready_o = (SB_DEPTH - count) >= 2. A lane is accepted when enableX_i & ready_o.
- Unaccepted lanes have no effect. Upstream holds its inputs until ready_o=1.
- All writeback and fault outputs are registered, with latency 1 cycle after acceptance. For a non-accepted or idle lane the next cycle gives wbEnable=0 and fault=0; data and address hold their previous values.
- Address range: addr = sOperand[ADDR_W-1:0]. A load-mem or store-mem is out of range if sOperand >= DEPTH. In that case:
  - fault pulses;
  - no writeback occurs;
  - no enqueue occurs.
- Op 0 and any undefined opcode: no writeback, no fault, no side effect.
- Op 10: wbEnable=isWb, wbData=sOperand, wbAddress=wbAddress_i.
- Op 11: wbEnable=isWb. Data comes from the first matching source in this priority order:
  - (a) lane B only: same-cycle accepted in-range lane A store to the same addr gives pOperandA;
  - (b) the youngest valid store-buffer entry with matching addr;
  - (c) dCache[addr].
- Lane A never sees a same-cycle lane B store.
- Op 12: wbEnable=0. The store {addr, pOperand} is enqueued at the tail. If both lanes store, A is enqueued before B, so B's data wins on equal addresses.
- Drain: when count > 0, the head entry is written to the cache each cycle and head advances.
  - Drain and enqueue may occur in the same cycle: count_next = count + enq - deq.
  - An entry draining this cycle is still visible to forwarding this cycle.
- Pointers wrap modulo SB_DEPTH. Overflow cannot occur because of the ready_o rule; count is asserted <= SB_DEPTH.
- sbEmpty_o = (count == 0), registered.
- Lanes decode fully independently; no lane's opcode affects the other lane's outputs.

Test Plan:
- Reset mid-drain: enqueue 3 stores, assert reset_i one cycle → next cycle sbEmpty_o=1, ready_o=1, all wb*/fault outputs 0, and a later load of those addresses returns 0.
- Forwarding: A store 0xBEEF to addr 7 and B load addr 7 in the same cycle → next cycle wbEnableB_o=1, wbDataB_o=0xBEEF. A load from addr 7 in the following cycle also returns 0xBEEF.
- Buffer forwarding priority: store 0x1111 then 0x2222 to addr 3 on consecutive cycles, then load addr 3 the next cycle before the drain completes → 0x2222.
- Backpressure: stores on both lanes every cycle → ready_o drops when count > 2. Every accepted store lands in the cache in order, and the final read-back of each address matches the last written value.
- Fault: DEPTH=20, load addr 25 on A with isWbA_i=1, plus load-imm 0x00AA on B → faultA_o=1 and wbEnableA_o=0; wbEnableB_o=1 with wbDataB_o=0x00AA.
- Independent lanes: A nop, B store 0x5A5A to addr 2 → wbEnableA_o=0 and wbEnableB_o=0, and addr 2 reads 0x5A5A after sbEmpty_o=1.
